// File: rtl/mmio_game_sequencer_if.sv
// rtl/mmio_game_sequencer_if.sv - processor-side MMIO port between the game sequencer and the game MMIO block
//
// Purpose: groups the memory-mapped bus so the sequencer (master) and the
// MMIO block (slave) share one connection.
// Signals:
//   wren    master->slave  write enable, one cycle per write
//   address master->slave  17-bit MMIO address
//   data    master->slave  32-bit write data
//   q_data  slave->master  registered read data (one cycle after address)
interface mmio_game_sequencer_if;
    logic        wren;
    logic [16:0] address;
    logic [31:0] data;
    logic [31:0] q_data;

    modport master (output wren, output address, output data, input q_data);
    modport slave  (input wren, input address, input data, output q_data);
endinterface

// File: rtl/mmio_game_sequencer.sv
// rtl/mmio_game_sequencer.sv - hardware game loop driving the game MMIO block
//
// Purpose: polls the key, VGA-frame and pipe flags, clears them, runs bird
// physics and scoring, and writes status, bird height and score back over
// the MMIO port in place of the software loop.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   enable        run while high; parks in S_IDLE at the next step boundary
//   bus           MMIO master port (wren/address/data out, q_data in)
//   status        mirror of the last game_status written
//   score_o       mirror of the last score written
//   busy          high whenever not in S_IDLE
// Optional feature macro: SEQ_COLLISION_EN (pipe collision check after PIPE).
module mmio_game_sequencer #(
    parameter logic [7:0] JUMP_KEY = 8'h29,
    parameter int         GRAVITY  = 2,
    parameter int         JUMP_VEL = 12,
    parameter int         MAX_FALL = 16,
    parameter int         Y_MAX    = 480,
    parameter int         Y_INIT   = 240
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    mmio_game_sequencer_if.master  bus,
    output logic [1:0]             status,
    output logic [7:0]             score_o,
    output logic                   busy
);

    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic signed [11:0] Y_TOP   = 12'(Y_MAX - 1);
    localparam logic signed [8:0]  VEL_MIN = 9'(-MAX_FALL);

    // Each bus read occupies an _A (address) and _W (wait) state; each
    // write occupies exactly one state.
    typedef enum logic [4:0] {
        S_IDLE,
`ifdef SEQ_COLLISION_EN
        C_PX_A, C_PX_W, C_PY_A, C_PY_W, C_ST,
`endif
        K_FLG_A, K_FLG_W, K_CODE_A, K_CODE_W, K_CLR, K_ST, K_SC,
        V_FLG_A, V_FLG_W, V_CLR, V_HGT, V_ST,
        P_FLG_A, P_FLG_W, P_SC, P_CLR
    } state_t;

    state_t state_q, state_d;

    logic [1:0]         status_q, status_d;
    logic [7:0]         score_q, score_d;
    logic signed [11:0] height_q, height_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [7:0]         key_code_q, key_code_d;
`ifdef SEQ_COLLISION_EN
    logic signed [31:0] px_q, px_d;
`endif

    // Any nonzero flag word reads as set.
    logic flag_set;
    assign flag_set = (bus.q_data != 32'd0);

    // Physics step, evaluated combinationally and committed on V_CLR.
    logic signed [8:0]  vel_dec;
    logic signed [7:0]  vel_new;
    logic signed [11:0] h_sum;
    logic signed [11:0] h_new;
    logic signed [7:0]  v_new;
    always_comb begin
        vel_dec = {vel_q[7], vel_q} - 9'(GRAVITY);
        vel_new = (vel_dec < VEL_MIN) ? VEL_MIN[7:0] : vel_dec[7:0];
        h_sum   = height_q + {{4{vel_new[7]}}, vel_new};
        h_new   = h_sum;
        v_new   = vel_new;
        if (h_sum > Y_TOP) begin
            h_new = Y_TOP;
            v_new = 8'sd0;
        end else if (h_sum <= 12'sd0) begin
            h_new = 12'sd0;
        end
    end

`ifdef SEQ_COLLISION_EN
    localparam int BIRD_X   = 160;
    localparam int PIPE_W   = 40;
    localparam int PIPE_GAP = 120;

    logic signed [31:0] py;
    logic signed [31:0] h_ext;
    logic               hit;
    always_comb begin
        py    = $signed(bus.q_data);
        h_ext = {{20{height_q[11]}}, height_q};
        hit   = (px_q >= 32'(BIRD_X - PIPE_W)) && (px_q <= 32'(BIRD_X))
                && ((h_ext < py) || (h_ext > py + 32'(PIPE_GAP)));
    end
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q   <= ST_READY;
            score_q    <= 8'd0;
            height_q   <= 12'(Y_INIT);
            vel_q      <= 8'sd0;
            key_code_q <= 8'd0;
`ifdef SEQ_COLLISION_EN
            px_q       <= 32'sd0;
`endif
        end else begin
            status_q   <= status_d;
            score_q    <= score_d;
            height_q   <= height_d;
            vel_q      <= vel_d;
            key_code_q <= key_code_d;
`ifdef SEQ_COLLISION_EN
            px_q       <= px_d;
`endif
        end
    end

    // Next-state and datapath update. enable is only sampled where a new
    // poll step would begin, so a step that has started always completes
    // its writes. status/score are committed on the edge that enters their
    // write state, so the mirrors change in the same cycle as the write.
    state_t key_entry, vga_entry, pipe_entry, after_pipe;
    always_comb begin
        key_entry  = enable ? K_FLG_A : S_IDLE;
        vga_entry  = enable ? V_FLG_A : S_IDLE;
        pipe_entry = enable ? P_FLG_A : S_IDLE;
`ifdef SEQ_COLLISION_EN
        after_pipe = (status_q == ST_PLAY) ? (enable ? C_PX_A : S_IDLE) : key_entry;
`else
        after_pipe = key_entry;
`endif

        state_d    = state_q;
        status_d   = status_q;
        score_d    = score_q;
        height_d   = height_q;
        vel_d      = vel_q;
        key_code_d = key_code_q;
`ifdef SEQ_COLLISION_EN
        px_d       = px_q;
`endif

        case (state_q)
            S_IDLE:   if (enable) state_d = K_FLG_A;
            K_FLG_A:  state_d = K_FLG_W;
            K_FLG_W:  state_d = flag_set ? K_CODE_A : vga_entry;
            K_CODE_A: state_d = K_CODE_W;
            K_CODE_W: begin
                key_code_d = bus.q_data[7:0];
                state_d    = K_CLR;
            end
            K_CLR: begin
                state_d = vga_entry;
                if (key_code_q == JUMP_KEY) begin
                    case (status_q)
                        ST_READY: begin
                            status_d = ST_PLAY;
                            height_d = 12'(Y_INIT);
                            vel_d    = 8'sd0;
                            state_d  = K_ST;
                        end
                        ST_PLAY: vel_d = 8'(JUMP_VEL);
                        ST_OVER: begin
                            status_d = ST_READY;
                            state_d  = K_ST;
                        end
                        default: ;
                    endcase
                end
            end
            // A game start is followed by the score reset write.
            K_ST: begin
                if (status_q == ST_PLAY) begin
                    score_d = 8'd0;
                    state_d = K_SC;
                end else begin
                    state_d = vga_entry;
                end
            end
            K_SC:     state_d = vga_entry;
            V_FLG_A:  state_d = V_FLG_W;
            V_FLG_W:  state_d = flag_set ? V_CLR : pipe_entry;
            V_CLR: begin
                if (status_q == ST_PLAY) begin
                    height_d = h_new;
                    vel_d    = v_new;
                    state_d  = V_HGT;
                end else begin
                    state_d = pipe_entry;
                end
            end
            // Height 0 after a physics step can only come from the floor clamp.
            V_HGT: begin
                if (height_q == 12'sd0) begin
                    status_d = ST_OVER;
                    state_d  = V_ST;
                end else begin
                    state_d = pipe_entry;
                end
            end
            V_ST:     state_d = pipe_entry;
            P_FLG_A:  state_d = P_FLG_W;
            P_FLG_W: begin
                if (!flag_set) begin
                    state_d = after_pipe;
                end else if (status_q == ST_PLAY) begin
                    score_d = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
                    state_d = P_SC;
                end else begin
                    state_d = P_CLR;
                end
            end
            P_SC:     state_d = P_CLR;
            P_CLR:    state_d = after_pipe;
`ifdef SEQ_COLLISION_EN
            C_PX_A:   state_d = C_PX_W;
            C_PX_W: begin
                px_d    = $signed(bus.q_data);
                state_d = C_PY_A;
            end
            C_PY_A:   state_d = C_PY_W;
            C_PY_W: begin
                if (hit) begin
                    status_d = ST_OVER;
                    state_d  = C_ST;
                end else begin
                    state_d = key_entry;
                end
            end
            C_ST:     state_d = key_entry;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Bus outputs decoded from the state
    always_comb begin
        bus.wren    = 1'b0;
        bus.address = 17'd0;
        bus.data    = 32'd0;
        case (state_q)
            K_FLG_A, K_FLG_W:   bus.address = 17'd6001;
            K_CODE_A, K_CODE_W: bus.address = 17'd6003;
            K_CLR: begin bus.wren = 1'b1; bus.address = 17'd6001; end
            K_ST, V_ST: begin
                bus.wren = 1'b1; bus.address = 17'd5000; bus.data = {30'd0, status_q};
            end
            K_SC, P_SC: begin
                bus.wren = 1'b1; bus.address = 17'd5002; bus.data = {24'd0, score_q};
            end
            V_FLG_A, V_FLG_W:   bus.address = 17'd6002;
            V_CLR: begin bus.wren = 1'b1; bus.address = 17'd6002; end
            V_HGT: begin
                bus.wren = 1'b1; bus.address = 17'd5001; bus.data = {20'd0, height_q};
            end
            P_FLG_A, P_FLG_W:   bus.address = 17'd6000;
            P_CLR: begin bus.wren = 1'b1; bus.address = 17'd6000; end
`ifdef SEQ_COLLISION_EN
            C_PX_A, C_PX_W:     bus.address = 17'd5003;
            C_PY_A, C_PY_W:     bus.address = 17'd5004;
            C_ST: begin
                bus.wren = 1'b1; bus.address = 17'd5000; bus.data = {30'd0, status_q};
            end
`endif
            default: ;
        endcase
        status  = status_q;
        score_o = score_q;
        busy    = (state_q != S_IDLE);
    end

endmodule
